// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: key codes, ALU
// operation encodings and the control FSM state set.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ENTRY_A,
    OP_SET,
    ENTRY_B,
    EXEC,
    RESULT,
    ERROR
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] key);
    return (key >= KEY_ADD) && (key <= KEY_DIV);
  endfunction

  function automatic alu_op_e key_to_op(input logic [3:0] key);
    alu_op_e op;
    case (key)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// Nibble-shift entry register: builds a hex operand one digit at a time and
// stops accepting digits once DIGITS have been entered.
module calc_operand_reg #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             set,
  input  logic             load,
  input  logic [3:0]       digit,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      // A loaded result is not a digit entry; mark the register full.
      value <= load_value;
      count <= CW'(DIGITS);
    end else if (set) begin
      value <= WIDTH'(digit);
      count <= CW'(1);
    end else if (shift && (count < CW'(DIGITS))) begin
      value <= {value[WIDTH-5:0], digit};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: collects operands from key events, runs the
// shared ALU over a start/done handshake and drives the display value/error.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 4,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_err
);

  localparam int TW = $clog2(ALU_TIMEOUT);

  state_e         state, state_next;
  alu_op_e        op, op_next, pend_op, pend_op_next;
  logic           pend, pend_next;
  logic [TW-1:0]  timer, timer_next;
  logic           start_next;
  logic           key_ev;
  logic           acc_clr, acc_shift, acc_set, acc_load;
  logic           opnd_clr, opnd_shift, opnd_set;
  logic [WIDTH-1:0] acc_value, opnd_value;

  assign key_ready = (state != EXEC);
  assign key_ev    = key_valid & key_ready;

  calc_operand_reg #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr        (acc_clr),
    .shift      (acc_shift),
    .set        (acc_set),
    .load       (acc_load),
    .digit      (key_code),
    .load_value (alu_result),
    .value      (acc_value)
  );

  calc_operand_reg #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_opnd (
    .clk        (clk),
    .rst        (rst),
    .clr        (opnd_clr),
    .shift      (opnd_shift),
    .set        (opnd_set),
    .load       (1'b0),
    .digit      (key_code),
    .load_value ('0),
    .value      (opnd_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ENTRY_A;
      op        <= OP_ADD;
      pend_op   <= OP_ADD;
      pend      <= 1'b0;
      timer     <= '0;
      alu_start <= 1'b0;
    end else begin
      state     <= state_next;
      op        <= op_next;
      pend_op   <= pend_op_next;
      pend      <= pend_next;
      timer     <= timer_next;
      alu_start <= start_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    op_next      = op;
    pend_op_next = pend_op;
    pend_next    = pend;
    timer_next   = '0;
    start_next   = 1'b0;
    acc_clr      = 1'b0;
    acc_shift    = 1'b0;
    acc_set      = 1'b0;
    acc_load     = 1'b0;
    opnd_clr     = 1'b0;
    opnd_shift   = 1'b0;
    opnd_set     = 1'b0;

    // key_ev is never true in EXEC, so clear is dropped there.
    if (key_ev && (key_code == KEY_CLR)) begin
      state_next   = ENTRY_A;
      op_next      = OP_ADD;
      pend_op_next = OP_ADD;
      pend_next    = 1'b0;
      acc_clr      = 1'b1;
      opnd_clr     = 1'b1;
    end else begin
      case (state)
        ENTRY_A: begin
          if (key_ev && is_digit(key_code)) begin
            acc_shift = 1'b1;
          end else if (key_ev && is_op(key_code)) begin
            op_next    = key_to_op(key_code);
            state_next = OP_SET;
          end
        end
        OP_SET: begin
          if (key_ev && is_digit(key_code)) begin
            opnd_set   = 1'b1;
            state_next = ENTRY_B;
          end else if (key_ev && is_op(key_code)) begin
            op_next = key_to_op(key_code);
          end
        end
        ENTRY_B: begin
          if (key_ev && is_digit(key_code)) begin
            opnd_shift = 1'b1;
          end else if (key_ev && (key_code == KEY_EQ)) begin
            start_next = 1'b1;
            state_next = EXEC;
          end else if (key_ev && is_op(key_code)) begin
            pend_next    = 1'b1;
            pend_op_next = key_to_op(key_code);
            start_next   = 1'b1;
            state_next   = EXEC;
          end
        end
        EXEC: begin
          timer_next = timer + 1'b1;
          if (alu_done && alu_err) begin
            pend_next  = 1'b0;
            state_next = ERROR;
          end else if (alu_done) begin
            acc_load = 1'b1;
            if (pend) begin
              op_next    = pend_op;
              pend_next  = 1'b0;
              state_next = OP_SET;
            end else begin
              state_next = RESULT;
            end
          end else if (timer == TW'(ALU_TIMEOUT - 1)) begin
            pend_next  = 1'b0;
            state_next = ERROR;
          end
        end
        RESULT: begin
          if (key_ev && is_op(key_code)) begin
            op_next    = key_to_op(key_code);
            state_next = OP_SET;
          end else if (key_ev && is_digit(key_code)) begin
            acc_set    = 1'b1;
            state_next = ENTRY_A;
          end
        end
        default: ;
      endcase
    end
  end

  // Operands and op only change outside EXEC, so they are stable while busy.
  assign alu_a      = acc_value;
  assign alu_b      = opnd_value;
  assign alu_op     = op;
  assign disp_value = ((state == ENTRY_B) || (state == EXEC)) ? opnd_value : acc_value;
  assign disp_err   = (state == ERROR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: a behavioural ALU responder checks
// each request against a scoreboard of expected operands and returns results.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] disp_value;
  logic        disp_err;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   start_count = 0;
  int   alu_lat = 3;
  logic alu_hold = 1'b0;
  logic late_tog = 1'b0;

  always #5 clk = ~clk;

  calc_sequencer #(.WIDTH(16), .DIGITS(4), .ALU_TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_err   (disp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_t r;
    r.a  = a;
    r.b  = b;
    r.op = op;
    exp_q.push_back(r);
  endtask

  // Called on a negedge; returns on the negedge after the key was sampled.
  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_exec", 32'(key_ready), 32'd1);
  endtask

  // Behavioural ALU: checks each request against the scoreboard and answers
  // alu_lat cycles after the start pulse unless held off.
  initial begin : alu_model
    int          cnt = 0;
    logic        late_seen = 1'b0;
    logic [15:0] res = '0;
    logic        err = 1'b0;
    req_t        r;
    alu_done   = 1'b0;
    alu_result = '0;
    alu_err    = 1'b0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (late_tog != late_seen) begin
        late_seen  = late_tog;
        alu_done   = 1'b1;
        alu_result = 16'h0055;
        alu_err    = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          alu_done   = 1'b1;
          alu_result = res;
          alu_err    = err;
        end
      end
      if (alu_start) begin
        start_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_alu_start", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("alu_a", 32'(alu_a), 32'(r.a));
          check("alu_b", 32'(alu_b), 32'(r.b));
          check("alu_op", 32'(alu_op), 32'(r.op));
          err = 1'b0;
          case (r.op)
            2'd0: res = r.a + r.b;
            2'd1: res = r.a - r.b;
            2'd2: res = r.a * r.b;
            default: begin
              if (r.b == 16'd0) begin
                res = '0;
                err = 1'b1;
              end else begin
                res = r.a / r.b;
              end
            end
          endcase
          if (!alu_hold) cnt = alu_lat - 1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int sc;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_disp_value", 32'(disp_value), 32'h0);
    check("reset_disp_err", 32'(disp_err), 32'd0);
    check("reset_key_ready", 32'(key_ready), 32'd1);
    check("reset_alu_start", 32'(alu_start), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1 + 1 = 2
    press(4'h1);
    check("entry_a_digit", 32'(disp_value), 32'h1);
    press(KEY_ADD);
    press(4'h1);
    push_exp(16'h1, 16'h1, OP_ADD);
    press(KEY_EQ);
    wait_ready();
    check("add_result", 32'(disp_value), 32'h2);
    check("one_start", 32'(start_count), 32'd1);

    // Chain from RESULT: 2 + 2 = 4
    press(KEY_ADD);
    check("op_keeps_acc", 32'(disp_value), 32'h2);
    press(4'h2);
    push_exp(16'h2, 16'h2, OP_ADD);
    press(KEY_EQ);
    wait_ready();
    check("chain_result", 32'(disp_value), 32'h4);

    // Leading/trailing zeros: 0x10 + 5
    press(KEY_CLR);
    check("clear_disp", 32'(disp_value), 32'h0);
    press(4'h1);
    press(4'h0);
    check("digits_1_0", 32'(disp_value), 32'h10);
    press(KEY_ADD);
    press(4'h5);
    push_exp(16'h10, 16'h5, OP_ADD);
    press(KEY_EQ);
    wait_ready();
    check("hex_add_result", 32'(disp_value), 32'h15);

    // Fifth digit ignored
    press(KEY_CLR);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    press(4'h5);
    check("digit_limit", 32'(disp_value), 32'h1234);

    // Divide by zero -> ERROR
    press(KEY_CLR);
    press(4'h4);
    press(KEY_DIV);
    press(4'h0);
    push_exp(16'h4, 16'h0, OP_DIV);
    press(KEY_EQ);
    wait_ready();
    check("div0_disp_err", 32'(disp_err), 32'd1);
    sc = start_count;
    press(4'h4);
    press(KEY_EQ);
    repeat (3) @(negedge clk);
    check("error_ignores_keys", 32'(disp_err), 32'd1);
    check("error_no_start", 32'(start_count), 32'(sc));
    press(KEY_CLR);
    check("error_clear_err", 32'(disp_err), 32'd0);
    check("error_clear_value", 32'(disp_value), 32'h0);

    // Operator in ENTRY_B chains: 9 - 4 = 5, then * 3 = 0xF
    press(4'h9);
    press(KEY_SUB);
    press(4'h4);
    push_exp(16'h9, 16'h4, OP_SUB);
    press(KEY_MUL);
    check("exec_key_ready", 32'(key_ready), 32'd0);
    wait_ready();
    check("chain_sub_result", 32'(disp_value), 32'h5);
    alu_lat = 10;
    press(4'h3);
    push_exp(16'h5, 16'h3, OP_MUL);
    press(KEY_EQ);
    press(KEY_CLR);
    wait_ready();
    check("chain_mul_result", 32'(disp_value), 32'hF);
    repeat (3) @(negedge clk);
    check("exec_key_dropped", 32'(disp_value), 32'hF);
    alu_lat = 3;

    // ALU never answers -> timeout after 64 cycles
    alu_hold = 1'b1;
    press(KEY_ADD);
    press(4'h2);
    push_exp(16'hF, 16'h2, OP_ADD);
    press(KEY_EQ);
    repeat (62) @(negedge clk);
    check("timeout_still_busy", 32'(key_ready), 32'd0);
    check("timeout_no_err_yet", 32'(disp_err), 32'd0);
    repeat (2) @(negedge clk);
    check("timeout_err", 32'(disp_err), 32'd1);
    press(KEY_CLR);
    check("timeout_clear", 32'(disp_err), 32'd0);

    // Reset mid-EXEC, then a late alu_done must be ignored
    press(4'h1);
    press(KEY_ADD);
    press(4'h2);
    push_exp(16'h1, 16'h2, OP_ADD);
    press(KEY_EQ);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midexec_rst_ready", 32'(key_ready), 32'd1);
    check("midexec_rst_value", 32'(disp_value), 32'h0);
    check("midexec_rst_err", 32'(disp_err), 32'd0);
    check("midexec_rst_start", 32'(alu_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    late_tog = ~late_tog;
    repeat (3) @(negedge clk);
    check("late_done_value", 32'(disp_value), 32'h0);
    check("late_done_ready", 32'(key_ready), 32'd1);
    alu_hold = 1'b0;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
